// File: rtl/speed_ramp_controller.sv
// Game-pace controller: turns variable-timer timeouts into asteroid steps,
// ramps Speed every STEPS_PER_LEVEL steps up to MAX_SPEED and keeps a saturating score.
module speed_ramp_controller #(
  parameter int STEPS_PER_LEVEL = 8,
  parameter int START_SPEED     = 1,
  parameter int MAX_SPEED       = 5
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       Pause,
  input  logic       GameOver,
  input  logic       TimeoutPulse,
  output logic       VarTimerEnable,
  output logic [3:0] Speed,
  output logic       StepPulse,
  output logic       LevelUp,
  output logic [7:0] Score
);

  // Handshake: TimeoutPulse, Start and GameOver are single-cycle strobes sampled
  // on the rising edge; every output is a flop and reflects that edge one cycle later.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST   = 8'(STEPS_PER_LEVEL - 1);
  localparam logic [3:0] SPEED_INIT = 4'(START_SPEED);
  localparam logic [3:0] SPEED_MAX  = 4'(MAX_SPEED);
  localparam logic [7:0] SCORE_MAX  = 8'hFF;

  state_t     state_q, state_d;
  logic       enable_q, enable_d;
  logic [3:0] speed_q, speed_d;
  logic [7:0] score_q, score_d;
  logic [7:0] cnt_q, cnt_d;
  logic       step_q, step_d;
  logic       level_q, level_d;
  logic       accept;
  logic       reload;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reload  = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        // GameOver is irrelevant here, so a coincident Start always wins.
        if (Start) begin
          state_d = S_RUN;
          reload  = 1'b1;
        end
      end
      S_RUN: begin
        if (GameOver) begin
          state_d = S_OVER;
        end else begin
          accept = TimeoutPulse;
          if (Pause) state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (GameOver)    state_d = S_OVER;
        else if (!Pause) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    speed_d = speed_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    level_d = 1'b0;

    if (reload) begin
      speed_d = SPEED_INIT;
      score_d = 8'd0;
      cnt_d   = 8'd0;
    end else if (accept) begin
      step_d = 1'b1;
      if (score_q != SCORE_MAX) score_d = score_q + 8'd1;
      // The level counter keeps wrapping at the ceiling; only Speed stops.
      if (cnt_q == CNT_LAST) begin
        cnt_d = 8'd0;
        if (speed_q < SPEED_MAX) begin
          speed_d = speed_q + 4'd1;
          level_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Enable tracks the next state so it is itself a registered output.
  always_comb begin
    enable_d = (state_d == S_RUN);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      enable_q <= 1'b0;
      speed_q  <= SPEED_INIT;
      score_q  <= 8'd0;
      cnt_q    <= 8'd0;
      step_q   <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      speed_q  <= speed_d;
      score_q  <= score_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      level_q  <= level_d;
    end
  end

  assign VarTimerEnable = enable_q;
  assign Speed          = speed_q;
  assign StepPulse      = step_q;
  assign LevelUp        = level_q;
  assign Score          = score_q;

endmodule

// File: tb/tb_speed_ramp_controller.sv
// Bench for speed_ramp_controller: directed stimulus, arithmetic game model,
// per-cycle output comparison and a level-up scoreboard.
module tb_speed_ramp_controller;

  localparam int SPL   = 8;
  localparam int START = 1;
  localparam int MAXS  = 5;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_OVER   = 3;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Start = 1'b0;
  logic       Pause = 1'b0;
  logic       GameOver = 1'b0;
  logic       TimeoutPulse = 1'b0;
  logic       VarTimerEnable;
  logic [3:0] Speed;
  logic       StepPulse;
  logic       LevelUp;
  logic [7:0] Score;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [7:0] exp_q[$];

  int m_mode  = M_IDLE;
  int m_steps = 0;
  bit m_step  = 1'b0;
  bit m_level = 1'b0;

  speed_ramp_controller #(
    .STEPS_PER_LEVEL(SPL),
    .START_SPEED    (START),
    .MAX_SPEED      (MAXS)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Start         (Start),
    .Pause         (Pause),
    .GameOver      (GameOver),
    .TimeoutPulse  (TimeoutPulse),
    .VarTimerEnable(VarTimerEnable),
    .Speed         (Speed),
    .StepPulse     (StepPulse),
    .LevelUp       (LevelUp),
    .Score         (Score)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_speed(input int steps);
    int s;
    s = START + steps / SPL;
    return (s > MAXS) ? MAXS : s;
  endfunction

  function automatic int exp_score(input int steps);
    return (steps > 255) ? 255 : steps;
  endfunction

  // Game model: a level is gained on every SPL-th step while the ceiling is not reached.
  always @(posedge Clk) begin
    m_step  = 1'b0;
    m_level = 1'b0;
    if (!Rst) begin
      m_mode  = M_IDLE;
      m_steps = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_OVER: if (Start) begin m_mode = M_RUN; m_steps = 0; end
        M_RUN: begin
          if (GameOver) m_mode = M_OVER;
          else begin
            if (TimeoutPulse) begin
              m_steps++;
              m_step  = 1'b1;
              m_level = (m_steps % SPL == 0) && (START + m_steps / SPL <= MAXS);
            end
            if (Pause) m_mode = M_PAUSED;
          end
        end
        default: begin
          if (GameOver)    m_mode = M_OVER;
          else if (!Pause) m_mode = M_RUN;
        end
      endcase
    end
  end

  // compare process
  always @(negedge Clk) begin
    if (chk_en) begin
      check("enable", int'(VarTimerEnable), int'(m_mode == M_RUN));
      check("speed",  int'(Speed),          exp_speed(m_steps));
      check("score",  int'(Score),          exp_score(m_steps));
      check("step",   int'(StepPulse),      int'(m_step));
      check("levelup", int'(LevelUp),       int'(m_level));
      if (LevelUp) begin
        if (exp_q.size() == 0) check("levelup_unexpected", int'(Score), 0);
        else check("levelup_at_step", int'(Score), int'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_start();
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
  endtask

  task automatic pulse_gameover();
    @(negedge Clk) GameOver = 1'b1;
    @(negedge Clk) GameOver = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) begin
      @(negedge Clk) TimeoutPulse = 1'b1;
      @(negedge Clk) TimeoutPulse = 1'b0;
    end
  endtask

  task automatic steps_b2b(input int n);
    @(negedge Clk) TimeoutPulse = 1'b1;
    repeat (n - 1) @(negedge Clk);
    @(negedge Clk) TimeoutPulse = 1'b0;
  endtask

  initial begin
    // Reset and start
    Rst = 1'b0;
    idle(3);
    chk_en = 1'b1;
    check("rst_enable", int'(VarTimerEnable), 0);
    check("rst_speed",  int'(Speed), 1);
    check("rst_score",  int'(Score), 0);
    check("rst_step",   int'(StepPulse), 0);
    @(negedge Clk) Rst = 1'b1;
    idle(2);
    pulse_start();
    check("start_enable", int'(VarTimerEnable), 1);
    check("start_speed",  int'(Speed), 1);
    check("start_score",  int'(Score), 0);

    // Level ramp and saturation
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i * SPL));
    steps(40);
    idle(1);
    check("ramp_score", int'(Score), 40);
    check("ramp_speed", int'(Speed), 5);
    check("ramp_levels_left", exp_q.size(), 0);

    // Start while running is ignored
    pulse_start();
    check("run_start_ignored", int'(Score), 40);

    // Pause
    pulse_gameover();
    pulse_start();
    steps(5);
    @(negedge Clk) Pause = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge Clk) TimeoutPulse = (i % 2 == 1);
    TimeoutPulse = 1'b0;
    idle(1);
    check("pause_enable", int'(VarTimerEnable), 0);
    check("pause_score",  int'(Score), 5);
    @(negedge Clk) Pause = 1'b0;
    idle(1);
    check("resume_enable", int'(VarTimerEnable), 1);
    exp_q.push_back(8'd8);
    steps(3);
    check("resume_speed", int'(Speed), 2);

    // TimeoutPulse + GameOver together
    @(negedge Clk) begin TimeoutPulse = 1'b1; GameOver = 1'b1; end
    @(negedge Clk) begin TimeoutPulse = 1'b0; GameOver = 1'b0; end
    check("over_score", int'(Score), 8);
    check("over_enable", int'(VarTimerEnable), 0);
    steps(2);
    check("over_ignores_steps", int'(Score), 8);

    // TimeoutPulse + Pause together
    pulse_start();
    steps(1);
    @(negedge Clk) begin TimeoutPulse = 1'b1; Pause = 1'b1; end
    @(negedge Clk) TimeoutPulse = 1'b0;
    check("tp_pause_score", int'(Score), 2);
    check("tp_pause_step",  int'(StepPulse), 1);
    check("tp_pause_enable", int'(VarTimerEnable), 0);
    @(negedge Clk) Pause = 1'b0;

    // Back-to-back steps then score saturation
    idle(1);
    steps_b2b(3);
    check("b2b_score", int'(Score), 5);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i * SPL));
    steps_b2b(300);
    check("sat_score", int'(Score), 255);
    check("sat_speed", int'(Speed), 5);
    pulse_gameover();
    idle(3);
    check("held_score", int'(Score), 255);
    check("held_speed", int'(Speed), 5);
    pulse_start();
    check("restart_speed", int'(Speed), 1);
    check("restart_score", int'(Score), 0);
    check("restart_enable", int'(VarTimerEnable), 1);

    // Reset mid-game
    exp_q.push_back(8'd8);
    exp_q.push_back(8'd16);
    steps(16);
    check("mid_speed", int'(Speed), 3);
    @(negedge Clk) Rst = 1'b0;
    @(negedge Clk) Rst = 1'b1;
    check("midrst_enable", int'(VarTimerEnable), 0);
    check("midrst_speed",  int'(Speed), 1);
    check("midrst_score",  int'(Score), 0);

    // Start + GameOver together from IDLE
    @(negedge Clk) begin Start = 1'b1; GameOver = 1'b1; end
    @(negedge Clk) begin Start = 1'b0; GameOver = 1'b0; end
    check("start_go_enable", int'(VarTimerEnable), 1);
    steps(2);
    check("final_score", int'(Score), 2);
    check("levels_left", exp_q.size(), 0);

    idle(2);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
